rp_seek_sequencer: RTL and testbench

//  Per-drive RPxx command sequencer. Accepts the GO strobe and function code

---
 rtl/rp_pkg.sv | 41 ++++
 rtl/rp_delay_cnt.sv | 30 +++
 rtl/rp_seek_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_rp_seek_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rp_pkg.sv
// Shared definitions for the RPxx seek sequencer: RPCS1 function codes (octal),
// FSM state encoding and command classification.
package rp_pkg;

  localparam int CYL_W_DEF = 10;

  // GO lives in bit 0 and never takes part in decode
  localparam logic [5:0] FUNC_MASK = 6'o76;

  localparam logic [5:0] F_NOP     = 6'o00;
  localparam logic [5:0] F_UNLOAD  = 6'o02;
  localparam logic [5:0] F_SEEK    = 6'o04;
  localparam logic [5:0] F_RECAL   = 6'o06;
  localparam logic [5:0] F_DRVCLR  = 6'o10;
  localparam logic [5:0] F_RELEASE = 6'o12;
  localparam logic [5:0] F_OFFSET  = 6'o14;
  localparam logic [5:0] F_RETCL   = 6'o16;
  localparam logic [5:0] F_PRESET  = 6'o20;
  localparam logic [5:0] F_PAKACK  = 6'o22;
  localparam logic [5:0] F_SEARCH  = 6'o30;
  localparam logic [5:0] F_DATA_LO = 6'o50;
  localparam logic [5:0] F_DATA_HI = 6'o72;

  typedef enum logic [2:0] {IDLE, SEEK, SRCH, XFER, DONE} state_t;

  // C_POS: seek/recal/offset/retcl; C_PULSE: drvclr/preset/pakack
  typedef enum logic [2:0] {C_NONE, C_POS, C_SRCH, C_DATA, C_PULSE, C_BAD} cmd_t;

  function automatic cmd_t classify(input logic [5:0] code);
    cmd_t c;
    case (code)
      F_SEEK, F_RECAL, F_OFFSET, F_RETCL: c = C_POS;
      F_SEARCH:                           c = C_SRCH;
      F_DRVCLR, F_PRESET, F_PAKACK:       c = C_PULSE;
      F_NOP, F_UNLOAD, F_RELEASE:         c = C_NONE;
      default: c = (code >= F_DATA_LO && code <= F_DATA_HI) ? C_DATA : C_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rp_delay_cnt.sv
// Loadable down-counter that parks at zero; zero flag is combinational from the count.
// Load takes effect on the next clock; no backpressure.
module rp_delay_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rp_seek_sequencer.sv
// Per-drive RPxx command sequencer: GO decode, seek/search/transfer sequencing, PIP/DRY/ATA drive.
// Registered status one cycle after GO; cmd* pulses same cycle; xfer_req held until xfer_ack. RP_SEEK_TIMING_EN enables real seek/search timing.
module rp_seek_sequencer
  import rp_pkg::*;
#(
  parameter int SEEK_BASE = 20,
  parameter int SEEK_STEP = 1,
  parameter int SRCH_DLY  = 10,
  parameter int CYL_W     = CYL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             go,
  input  logic [5:0]       func,
  input  logic [CYL_W-1:0] tgt_cyl,
  input  logic             rpCD,
  input  logic             err,
  input  logic             xfer_ack,
  output logic             setPIP,
  output logic             setDRY,
  output logic             setATA,
  output logic             cmdDRVCLR,
  output logic             cmdPRESET,
  output logic             cmdPAKACK,
  output logic             xfer_req,
  output logic [CYL_W-1:0] cur_cyl
);

  // Counter preloads are base-1 and dly-1, so both must be at least one cycle
  if (SEEK_BASE < 1 || SEEK_STEP < 0 || SRCH_DLY < 1 || CYL_W < 1) begin : gParamCheck
    $error("rp_seek_sequencer: SEEK_BASE/SRCH_DLY must be >= 1, SEEK_STEP >= 0");
  end

  state_t           state;
  cmd_t             cmdQ;
  logic [CYL_W-1:0] tgtQ;
  logic             cdQ;

  logic [5:0]       code;
  cmd_t             cls;
  logic [CYL_W-1:0] newTgt;
  logic             goIdle, cdFall, drvClr, startSeek, phaseEnd;

  assign code      = func & FUNC_MASK;
  assign cls       = classify(code);
  assign cdFall    = cdQ & ~rpCD;
  assign goIdle    = go & rpCD & (state == IDLE);
  assign drvClr    = go & rpCD & (code == F_DRVCLR);
  assign startSeek = goIdle & ~err & (cls == C_POS || cls == C_SRCH || cls == C_DATA);

  assign cmdDRVCLR = drvClr;
  assign cmdPRESET = goIdle & ~err & (code == F_PRESET);
  assign cmdPAKACK = goIdle & ~err & (code == F_PAKACK);

  always_comb begin
    case (code)
      F_RECAL:           newTgt = '0;
      F_OFFSET, F_RETCL: newTgt = cur_cyl;
      default:           newTgt = tgt_cyl;
    endcase
  end

`ifdef RP_SEEK_TIMING_EN
  localparam int CNT_W = 16;

  logic [CYL_W:0]   cylDiff;
  logic [CNT_W-1:0] seekLen, cntVal;
  logic             cntLoad, cntZero;

  // One counter serves both phases: seek length at GO, search delay at seek end
  always_comb begin
    cylDiff = (newTgt >= cur_cyl) ? ({1'b0, newTgt} - {1'b0, cur_cyl})
                                  : ({1'b0, cur_cyl} - {1'b0, newTgt});
    seekLen = CNT_W'(SEEK_BASE) + CNT_W'(SEEK_STEP) * CNT_W'(cylDiff) - CNT_W'(1);
    cntLoad = startSeek | ((state == SEEK) & cntZero & (cmdQ != C_POS));
    cntVal  = (state == IDLE) ? seekLen : CNT_W'(SRCH_DLY - 1);
  end

  rp_delay_cnt #(.W(CNT_W)) uDelay (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .load    (cntLoad),
    .loadVal (cntVal),
    .zero    (cntZero)
  );

  assign phaseEnd = cntZero;
`else
  assign phaseEnd = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cmdQ     <= C_NONE;
      tgtQ     <= '0;
      cur_cyl  <= '0;
      cdQ      <= 1'b0;
      setPIP   <= 1'b0;
      setDRY   <= 1'b0;
      setATA   <= 1'b0;
      xfer_req <= 1'b0;
    end else if (clr) begin
      state    <= IDLE;
      cmdQ     <= C_NONE;
      tgtQ     <= '0;
      cur_cyl  <= '0;
      cdQ      <= 1'b0;
      setPIP   <= 1'b0;
      setDRY   <= 1'b0;
      setATA   <= 1'b0;
      xfer_req <= 1'b0;
    end else begin
      cdQ    <= rpCD;
      setATA <= 1'b0;
      if (cdFall) begin
        state    <= IDLE;
        setPIP   <= 1'b0;
        setDRY   <= 1'b1;
        setATA   <= 1'b1;
        xfer_req <= 1'b0;
      end else if (drvClr) begin
        // drive clear abandons any command quietly; head stays where it is
        state    <= IDLE;
        setPIP   <= 1'b0;
        setDRY   <= 1'b1;
        xfer_req <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            setDRY <= 1'b1;
            if (goIdle && (err || cls == C_BAD)) begin
              setATA <= 1'b1;
            end else if (startSeek) begin
              state  <= SEEK;
              cmdQ   <= cls;
              tgtQ   <= newTgt;
              setPIP <= 1'b1;
              setDRY <= 1'b0;
            end
          end
          SEEK: begin
            if (phaseEnd) begin
              cur_cyl <= tgtQ;
              setPIP  <= 1'b0;
              if (cmdQ == C_POS) begin
                state  <= DONE;
                setDRY <= 1'b1;
                setATA <= 1'b1;
              end else begin
                state <= SRCH;
              end
            end
          end
          SRCH: begin
            if (phaseEnd) begin
              if (cmdQ == C_DATA) begin
                state    <= XFER;
                xfer_req <= 1'b1;
              end else begin
                state  <= DONE;
                setDRY <= 1'b1;
                setATA <= 1'b1;
              end
            end
          end
          XFER: begin
            if (xfer_ack) begin
              state    <= DONE;
              xfer_req <= 1'b0;
              setDRY   <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rp_seek_sequencer.sv
// Self-checking bench for rp_seek_sequencer: directed corner cases plus randomized
// commands scored against a transaction-level model of the drive timing.
module tb_rp_seek_sequencer;

  localparam int SEEK_BASE = 20;
  localparam int SEEK_STEP = 1;
  localparam int SRCH_DLY  = 10;
`ifdef RP_SEEK_TIMING_EN
  localparam bit TIMED = 1'b1;
`else
  localparam bit TIMED = 1'b0;
`endif

  localparam logic [5:0] F_SEEK   = 6'o04;
  localparam logic [5:0] F_RECAL  = 6'o06;
  localparam logic [5:0] F_DRVCLR = 6'o10;
  localparam logic [5:0] F_OFFSET = 6'o14;
  localparam logic [5:0] F_RETCL  = 6'o16;
  localparam logic [5:0] F_PRESET = 6'o20;
  localparam logic [5:0] F_PAKACK = 6'o22;
  localparam logic [5:0] F_SEARCH = 6'o30;
  localparam logic [5:0] F_READ   = 6'o70;

  logic       clk = 1'b0;
  logic       rst, clr, go, rpCD, err, xfer_ack;
  logic [5:0] func;
  logic [9:0] tgt_cyl;
  logic       setPIP, setDRY, setATA, cmdDRVCLR, cmdPRESET, cmdPAKACK, xfer_req;
  logic [9:0] cur_cyl;

  int checks = 0;
  int errors = 0;
  int modelCyl = 0;

  rp_seek_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .go        (go),
    .func      (func),
    .tgt_cyl   (tgt_cyl),
    .rpCD      (rpCD),
    .err       (err),
    .xfer_ack  (xfer_ack),
    .setPIP    (setPIP),
    .setDRY    (setDRY),
    .setATA    (setATA),
    .cmdDRVCLR (cmdDRVCLR),
    .cmdPRESET (cmdPRESET),
    .cmdPAKACK (cmdPAKACK),
    .xfer_req  (xfer_req),
    .cur_cyl   (cur_cyl)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int seekCycles(input int from, input int to);
    int d;
    d = (to > from) ? to - from : from - to;
    return TIMED ? SEEK_BASE + SEEK_STEP * d : 1;
  endfunction

  function automatic int srchCycles();
    return TIMED ? SRCH_DLY : 1;
  endfunction

  // One command from IDLE; called and returns on a falling edge.
  task automatic txn(input logic [5:0] code, input int tgt, input logic errIn, input int ackDly);
    int s = 0, r = 0, xq = 0, expAta = 0, expAtaFirst = 0, expXqFirst = 0, target, win;
    bit moves = 0, search = 0, data = 0;
    int pipC = 0, ataC = 0, ataFirst = 0, dryLowC = 0, xqC = 0, xqFirst = 0;
    target = modelCyl;
    if (errIn && code != F_DRVCLR) expAta = 1;
    else if (code == F_SEEK || code == F_SEARCH) begin
      target = tgt; moves = 1; search = (code == F_SEARCH);
    end else if (code == F_RECAL) begin
      target = 0; moves = 1;
    end else if (code == F_OFFSET || code == F_RETCL) moves = 1;
    else if (code >= 6'o50 && code <= 6'o72) begin
      target = tgt; moves = 1; data = 1;
    end else if (!(code inside {6'o00, 6'o02, 6'o12, F_DRVCLR, F_PRESET, F_PAKACK})) expAta = 1;
    if (moves) begin
      s = seekCycles(modelCyl, target);
      r = (search || data) ? srchCycles() : 0;
      xq = data ? ackDly + 1 : 0;
      expAta = data ? 0 : 1;
      expAtaFirst = data ? 0 : s + r + 1;
      expXqFirst = data ? s + r + 1 : 0;
    end else if (expAta == 1) expAtaFirst = 1;

    go = 1'b1; func = code | 6'o01; tgt_cyl = 10'(tgt); err = errIn;
    #1;
    chk("cmdDRVCLR", cmdDRVCLR, 32'(code == F_DRVCLR));
    chk("cmdPRESET", cmdPRESET, 32'(!errIn && code == F_PRESET));
    chk("cmdPAKACK", cmdPAKACK, 32'(!errIn && code == F_PAKACK));
    win = s + r + xq + 6;
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      go = 1'b0; err = 1'b0;
      if (setPIP) pipC++;
      if (!setDRY) dryLowC++;
      if (setATA) begin ataC++; if (ataFirst == 0) ataFirst = k; end
      if (xfer_req) begin xqC++; if (xqFirst == 0) xqFirst = k; end
      xfer_ack = (xqFirst != 0 && k == xqFirst + ackDly);
    end
    chk("pip_cycles", pipC, s);
    chk("dry_low_cycles", dryLowC, s + r + xq);
    chk("ata_count", ataC, expAta);
    chk("ata_first", ataFirst, expAtaFirst);
    chk("xreq_cycles", xqC, xq);
    chk("xreq_first", xqFirst, expXqFirst);
    chk("cur_cyl", cur_cyl, target);
    chk("dry_end", setDRY, 1);
    modelCyl = target;
  endtask

  logic [5:0] codes [13] = '{6'o04, 6'o06, 6'o14, 6'o16, 6'o30, 6'o50, 6'o60,
                             6'o70, 6'o00, 6'o20, 6'o22, 6'o26, 6'o10};

  initial begin
    bit seen;
    int t;
    rst = 1'b1; clr = 1'b0; go = 1'b0; func = '0; tgt_cyl = '0;
    rpCD = 1'b1; err = 1'b0; xfer_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pip", setPIP, 0);
    chk("rst_dry", setDRY, 0);
    chk("rst_ata", setATA, 0);
    chk("rst_xreq", xfer_req, 0);
    chk("rst_cyl", cur_cyl, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_dry", setDRY, 1);

    // Directed scenarios
    txn(F_SEEK, 100, 1'b0, 1);
    txn(F_READ, 100, 1'b0, 5);
    txn(F_SEEK, 200, 1'b1, 1);
    txn(F_RECAL, 0, 1'b0, 1);
    txn(F_SEARCH, 37, 1'b0, 1);
    txn(6'o34, 9, 1'b0, 1);

    // Drive clear while positioning
    go = 1'b1; func = F_SEEK | 6'o01; tgt_cyl = 10'd300;
    @(negedge clk);
    chk("dc_pip_before", setPIP, 1);
    func = F_DRVCLR | 6'o01;
    #1 chk("dc_cmd", cmdDRVCLR, 1);
    @(negedge clk);
    go = 1'b0;
    chk("dc_pip", setPIP, 0);
    chk("dc_dry", setDRY, 1);
    chk("dc_cyl", cur_cyl, modelCyl);
    seen = 0;
    repeat (4) begin @(negedge clk); if (setATA) seen = 1; end
    chk("dc_no_ata", seen, 0);

    // GO while busy is ignored; media removal during transfer aborts
    t = $urandom_range(0, 300);
    go = 1'b1; func = F_READ | 6'o01; tgt_cyl = 10'(t);
    @(negedge clk); go = 1'b0;
    seen = 0;
    for (int k = 0; k < 2000 && !seen; k++) begin @(negedge clk); seen = xfer_req; end
    chk("xreq_seen", seen, 1);
    modelCyl = t;
    go = 1'b1; func = F_SEEK | 6'o01; tgt_cyl = 10'd5;
    @(negedge clk); go = 1'b0;
    chk("busy_pip", setPIP, 0);
    chk("busy_xreq", xfer_req, 1);
    rpCD = 1'b0;
    @(negedge clk);
    chk("cd_xreq", xfer_req, 0);
    chk("cd_ata", setATA, 1);
    chk("cd_dry", setDRY, 1);
    chk("cd_cyl", cur_cyl, modelCyl);
    go = 1'b1; func = F_PRESET | 6'o01;
    #1 chk("offline_preset", cmdPRESET, 0);
    @(negedge clk);
    chk("cd_ata_off", setATA, 0);
    func = F_SEEK | 6'o01; tgt_cyl = 10'd50;
    @(negedge clk); go = 1'b0;
    @(negedge clk);
    chk("offline_pip", setPIP, 0);
    chk("offline_cyl", cur_cyl, modelCyl);
    rpCD = 1'b1;
    xfer_ack = 1'b1;
    @(negedge clk); xfer_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_dry", setDRY, 1);
    chk("stray_ack_ata", setATA, 0);

    // Controller clear during a seek
    go = 1'b1; func = F_SEEK | 6'o01; tgt_cyl = 10'd40;
    @(negedge clk); go = 1'b0;
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_pip", setPIP, 0);
    chk("clr_cyl", cur_cyl, 0);
    modelCyl = 0;
    @(negedge clk);
    chk("clr_dry", setDRY, 1);

    // Randomized commands
    for (int i = 0; i < 24; i++) begin
      txn(codes[$urandom_range(0, 12)], int'($urandom_range(0, 300)),
          logic'($urandom_range(0, 7) == 0), int'($urandom_range(1, 8)));
    end

    // Asynchronous reset during the search phase
    go = 1'b1; func = F_SEARCH | 6'o01; tgt_cyl = 10'd77;
    @(negedge clk); go = 1'b0;
    seen = 0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      if (!setPIP) seen = 1; else @(negedge clk);
    end
    chk("srch_reached", seen, 1);
    rst = 1'b1;
    #1;
    chk("rrst_pip", setPIP, 0);
    chk("rrst_dry", setDRY, 0);
    chk("rrst_xreq", xfer_req, 0);
    chk("rrst_cyl", cur_cyl, 0);
    modelCyl = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rrst_dry_after", setDRY, 1);
    txn(F_SEEK, 12, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
